demux_deserializer: RTL and testbench
=====================================

Name: demux_deserializer

Overview:
- Inverse of the mux primitive: a stream of DATA_WIDTH words is steered round-robin into 2**SELECT_LINES lanes of one wide frame register.
- Each completed frame is presented as a single wide word with valid/ready handshake.
- Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], the same packing the mux data_in port uses. A mux driven with select=k on this output returns the k-th word written.
- Sits between narrow sample streams and wide-bus consumers in the library.

Parameters:
- ARCHITECTURE, "BEHAVIORAL", implementation selector; only "BEHAVIORAL" is required.
- SELECT_LINES, 4, lane index width; N = 2**SELECT_LINES lanes; must be >= 1.
- DATA_WIDTH, 2, width of one input word / one lane.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  DATA_WIDTH  input word.
- data_in_valid  in  1  data_in is valid this cycle.
- data_in_ready  out  1  block accepts data_in this cycle.
- sync_in  in  1  frame-alignment strobe; forces lane 0.
- data_out  out  DATA_WIDTH*2**SELECT_LINES  assembled frame.
- data_out_valid  out  1  data_out holds an unconsumed frame.
- data_out_ready  in  1  downstream takes the frame.
- select_out  out  SELECT_LINES  lane the next accepted word will fill.
- sync_err  out  1  one-cycle pulse: sync arrived mid-frame.

Behaviour:
- Reset (rst_n=0 at clk edge): lane counter=0, assembly reg=0, data_out=0, data_out_valid=0, sync_err=0. Reset wins over every other input. A partial frame is discarded. A held output frame is dropped.
- accept = data_in_valid & data_in_ready. Lane = 0 if sync_in=1, else counter.
- On accept: assembly[lane] <= data_in.
  - If lane != N-1: counter <= lane+1.
  - If lane == N-1: data_out <= assembly with the new word merged; data_out_valid <= 1; counter <= 0.
- Latency: data_out_valid rises the cycle after the last word of a frame is accepted.
- data_in_ready = ~(counter==N-1 & data_out_valid & ~data_out_ready). This is combinational from data_out_ready.
  - The block stalls only on the final word, when the previous frame is still unconsumed.
  - Lanes 0..N-2 are always accepted while a frame is held.
- data_out_valid clears on data_out_ready=1 unless a new frame lands in the same cycle. In that case it stays 1 with the new data. data_out stays stable while valid & ~ready.
- sync_in with accept: word goes to lane 0. Counter <= 1, or for N=1 the frame completes. Earlier partial words are discarded and their assembly lanes cleared to 0.
- sync_in without accept: counter <= 0; partial frame discarded and assembly cleared.
- sync_err pulses 1 for one cycle when sync_in=1 and counter != 0. sync_in at counter==0 is silent.
- sync_in has no effect on data_out or data_out_valid.
- select_out = counter (registered). Wrap N-1 -> 0 is the normal frame boundary, not an error.
- data_in_valid=0 holds all state. Data is never dropped, duplicated or reordered except the partial-frame discard on sync.
- N=1 (SELECT_LINES=0) is unsupported.

Test Plan (defaults DATA_WIDTH=2, SELECT_LINES=4, N=16, data_out 32 bits):
1. Reset: rst_n=0 with valid stimulus for 3 cycles -> data_out=0, data_out_valid=0, select_out=0, sync_err=0, data_in_ready=1.
2. Streaming: data_out_ready=1; feed words 0,1,2,3 repeating, 16 consecutive valid cycles -> data_out_valid high for exactly 1 cycle, one cycle after word 16; data_out=0xE4E4E4E4; select_out wraps 15->0.
3. Back-pressure: data_out_ready=0; send 32 words (frame A all 3, then frame B all 1).
   - Words 17..31 accepted.
   - data_in_ready=0 on word 32 while data_out=0xFFFFFFFF.
   - Raise ready -> word 32 accepted that cycle; next cycle data_out=0x55555555, valid=1.
4. Mid-frame sync: 5 words of 3, then sync_in=1 with word 2, then 15 words of 0.
   - sync_err one-cycle pulse.
   - Frame = 0x00000002 (lanes 1-4 not carried over).
5. Aligned sync: sync_in=1 on the first word of a frame -> no sync_err; frame identical to scenario 2 without sync.
6. Reset mid-frame: 7 words accepted, rst_n=0 for 1 cycle, then 16 words of 1 -> select_out=0 after reset; single frame 0x55555555; no stale lanes.
7. Round-trip: feed demux output to a mux (same parameters), sweep select 0..15 -> mux output equals the k-th input word.

Source files
------------

// File: rtl/demux_deserializer.sv
// Round-robin word-to-lane deserializer: DATA_WIDTH words fill 2**SELECT_LINES
// lanes of a frame register, and each completed frame is offered with valid/ready.
module demux_deserializer #(
  parameter     ARCHITECTURE = "BEHAVIORAL",
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic                                  data_in_valid,
  output logic                                  data_in_ready,
  input  logic                                  sync_in,
  output logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  output logic [SELECT_LINES-1:0]               select_out,
  output logic                                  sync_err
);

  localparam int N       = 2**SELECT_LINES;
  localparam int FRAME_W = N * DATA_WIDTH;
  localparam logic [SELECT_LINES-1:0] LAST_LANE = {SELECT_LINES{1'b1}};

  function automatic logic [FRAME_W-1:0] put_lane(
    input logic [FRAME_W-1:0]      frame,
    input logic [SELECT_LINES-1:0] idx,
    input logic [DATA_WIDTH-1:0]   word
  );
    logic [FRAME_W-1:0] f;
    f = frame;
    f[int'(idx)*DATA_WIDTH +: DATA_WIDTH] = word;
    return f;
  endfunction

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
    logic [SELECT_LINES-1:0] lane_cnt;
    logic [SELECT_LINES-1:0] lane_cnt_nxt;
    logic [SELECT_LINES-1:0] lane;
    logic [FRAME_W-1:0]      asm_r;
    logic [FRAME_W-1:0]      asm_nxt;
    logic                    accept;
    logic                    frame_done;

    // Only the closing word of a frame can collide with a still-held output frame.
    assign data_in_ready = ~((lane_cnt == LAST_LANE) & data_out_valid & ~data_out_ready);
    assign accept        = data_in_valid & data_in_ready;
    assign lane          = sync_in ? '0 : lane_cnt;
    assign frame_done    = accept & (lane == LAST_LANE);
    assign select_out    = lane_cnt;

    always_comb begin
      asm_nxt      = sync_in ? '0 : asm_r;
      lane_cnt_nxt = lane_cnt;
      if (accept) begin
        asm_nxt      = put_lane(asm_nxt, lane, data_in);
        lane_cnt_nxt = frame_done ? '0 : lane + SELECT_LINES'(1);
      end else if (sync_in) begin
        lane_cnt_nxt = '0;
      end
    end

    // Frame assembly / output stage boundary
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lane_cnt       <= '0;
        asm_r          <= '0;
        data_out       <= '0;
        data_out_valid <= 1'b0;
        sync_err       <= 1'b0;
      end else begin
        lane_cnt <= lane_cnt_nxt;
        asm_r    <= asm_nxt;
        sync_err <= sync_in & (lane_cnt != '0);
        if (frame_done) begin
          data_out       <= asm_nxt;
          data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
          data_out_valid <= 1'b0;
        end
      end
    end
  end else begin : g_unsupported
    assign data_in_ready  = 1'b0;
    assign data_out       = '0;
    assign data_out_valid = 1'b0;
    assign select_out     = '0;
    assign sync_err       = 1'b0;
  end

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed bench for demux_deserializer at default parameters (N=16 lanes of 2 bits).
module tb_demux_deserializer;
  localparam int SL = 4;
  localparam int DW = 2;
  localparam int N  = 16;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic          sync_in;
  logic [FW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [SL-1:0] select_out;
  logic          sync_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_deserializer #(
    .ARCHITECTURE("BEHAVIORAL"),
    .SELECT_LINES(SL),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .sync_in       (sync_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .select_out    (select_out),
    .sync_err      (sync_err)
  );

  // Present one word for one clock edge; returns on the following negedge.
  task automatic push(input logic [DW-1:0] w, input logic s);
    data_in       = w;
    data_in_valid = 1'b1;
    sync_in       = s;
    @(negedge clk);
    data_in_valid = 1'b0;
    sync_in       = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data_in = 2'd3; data_in_valid = 1'b1; sync_in = 1'b1; data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    data_in_valid = 1'b0; sync_in = 1'b0;
    #1;
    checks++; if (data_out !== 32'h0) begin errs++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
    checks++; if (data_out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
    checks++; if (select_out !== 4'd0) begin errs++; $display("FAIL reset_select: got %0d expected 0", select_out); end
    checks++; if (sync_err !== 1'b0) begin errs++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    checks++; if (data_in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", data_in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming;
    data_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++; if (select_out !== 4'(i)) begin errs++; $display("FAIL stream_select[%0d]: got %0d expected %0d", i, select_out, i); end
      if (i == N-1) begin
        checks++; if (data_out_valid !== 1'b0) begin errs++; $display("FAIL stream_valid_early: got %b expected 0", data_out_valid); end
      end
      push(2'(i % 4), 1'b0);
    end
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL stream_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== 32'hE4E4E4E4) begin errs++; $display("FAIL stream_data: got %h expected %h", data_out, 32'hE4E4E4E4); end
    checks++; if (select_out !== 4'd0) begin errs++; $display("FAIL stream_wrap: got %0d expected 0", select_out); end
    @(negedge clk);
    checks++; if (data_out_valid !== 1'b0) begin errs++; $display("FAIL stream_valid_pulse: got %b expected 0", data_out_valid); end
  endtask

  task automatic test_back_pressure;
    data_out_ready = 1'b0;
    for (int i = 0; i < N; i++) push(2'd3, 1'b0);
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL bp_frame_a_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== 32'hFFFFFFFF) begin errs++; $display("FAIL bp_frame_a_data: got %h expected %h", data_out, 32'hFFFFFFFF); end
    for (int i = 0; i < N-1; i++) begin
      data_in = 2'd1; data_in_valid = 1'b1;
      #1;
      checks++; if (data_in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_word%0d: got %b expected 1", 17+i, data_in_ready); end
      @(negedge clk);
    end
    data_in = 2'd1; data_in_valid = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b0) begin errs++; $display("FAIL bp_stall_ready: got %b expected 0", data_in_ready); end
    @(negedge clk);
    checks++; if (select_out !== 4'd15) begin errs++; $display("FAIL bp_stall_select: got %0d expected 15", select_out); end
    checks++; if (data_out !== 32'hFFFFFFFF) begin errs++; $display("FAIL bp_hold_data: got %h expected %h", data_out, 32'hFFFFFFFF); end
    data_out_ready = 1'b1;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready: got %b expected 1", data_in_ready); end
    @(negedge clk);
    data_in_valid = 1'b0;
    checks++; if (data_out !== 32'h55555555) begin errs++; $display("FAIL bp_frame_b_data: got %h expected %h", data_out, 32'h55555555); end
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL bp_frame_b_valid: got %b expected 1", data_out_valid); end
    checks++; if (select_out !== 4'd0) begin errs++; $display("FAIL bp_frame_b_select: got %0d expected 0", select_out); end
    @(negedge clk);
    checks++; if (data_out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b expected 0", data_out_valid); end
  endtask

  task automatic test_mid_sync;
    data_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(2'd3, 1'b0);
    push(2'd2, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errs++; $display("FAIL midsync_err: got %b expected 1", sync_err); end
    checks++; if (select_out !== 4'd1) begin errs++; $display("FAIL midsync_select: got %0d expected 1", select_out); end
    push(2'd0, 1'b0);
    checks++; if (sync_err !== 1'b0) begin errs++; $display("FAIL midsync_err_pulse: got %b expected 0", sync_err); end
    for (int i = 0; i < 14; i++) push(2'd0, 1'b0);
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL midsync_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== 32'h00000002) begin errs++; $display("FAIL midsync_data: got %h expected %h", data_out, 32'h00000002); end
    @(negedge clk);
  endtask

  task automatic test_idle_sync;
    for (int i = 0; i < 3; i++) push(2'd1, 1'b0);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    checks++; if (select_out !== 4'd0) begin errs++; $display("FAIL idlesync_select: got %0d expected 0", select_out); end
    checks++; if (sync_err !== 1'b1) begin errs++; $display("FAIL idlesync_err: got %b expected 1", sync_err); end
    checks++; if (data_out !== 32'h00000002) begin errs++; $display("FAIL idlesync_data_kept: got %h expected %h", data_out, 32'h00000002); end
    @(negedge clk);
  endtask

  task automatic test_aligned_sync;
    push(2'd0, 1'b1);
    checks++; if (sync_err !== 1'b0) begin errs++; $display("FAIL aligned_err: got %b expected 0", sync_err); end
    checks++; if (select_out !== 4'd1) begin errs++; $display("FAIL aligned_select: got %0d expected 1", select_out); end
    for (int i = 1; i < N; i++) push(2'(i % 4), 1'b0);
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL aligned_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== 32'hE4E4E4E4) begin errs++; $display("FAIL aligned_data: got %h expected %h", data_out, 32'hE4E4E4E4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 7; i++) push(2'd2, 1'b0);
    checks++; if (select_out !== 4'd7) begin errs++; $display("FAIL rstmid_pre_select: got %0d expected 7", select_out); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (select_out !== 4'd0) begin errs++; $display("FAIL rstmid_select: got %0d expected 0", select_out); end
    checks++; if (data_out !== 32'h0) begin errs++; $display("FAIL rstmid_data: got %h expected %h", data_out, 32'h0); end
    for (int i = 0; i < N; i++) push(2'd1, 1'b0);
    checks++; if (data_out_valid !== 1'b1) begin errs++; $display("FAIL rstmid_valid: got %b expected 1", data_out_valid); end
    checks++; if (data_out !== 32'h55555555) begin errs++; $display("FAIL rstmid_frame: got %h expected %h", data_out, 32'h55555555); end
    @(negedge clk);
  endtask

  task automatic test_round_trip;
    logic [DW-1:0] words [N];
    logic [DW-1:0] mux_out;
    for (int k = 0; k < N; k++) words[k] = 2'((k ^ (k >> 2)) & 3);
    for (int k = 0; k < N; k++) push(words[k], 1'b0);
    for (int k = 0; k < N; k++) begin
      mux_out = data_out[k*DW +: DW];
      checks++; if (mux_out !== words[k]) begin errs++; $display("FAIL roundtrip_sel%0d: got %0d expected %0d", k, mux_out, words[k]); end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_mid_sync();
    test_idle_sync();
    test_aligned_sync();
    test_reset_mid_frame();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
